// File: rtl/seq_divider_if.sv
// Handshake/operand bundle for seq_divider. The Signed input exists only
// when SEQ_DIVIDER_SIGNED_EN is defined.
interface seq_divider_if #(
  parameter int N = 32
);
  logic         Start;
  logic [N-1:0] Dividend;
  logic [N-1:0] Divisor;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         Busy;
  logic         Done;
  logic         DivByZero;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic         Signed;

  modport master (
    output Start, Dividend, Divisor, Signed,
    input  Quotient, Remainder, Busy, Done, DivByZero
  );
  modport slave (
    input  Start, Dividend, Divisor, Signed,
    output Quotient, Remainder, Busy, Done, DivByZero
  );
`else
  modport master (
    output Start, Dividend, Divisor,
    input  Quotient, Remainder, Busy, Done, DivByZero
  );
  modport slave (
    input  Start, Dividend, Divisor,
    output Quotient, Remainder, Busy, Done, DivByZero
  );
`endif
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring sequential divider, one quotient bit per cycle.
// Optional two's-complement mode is enabled by defining SEQ_DIVIDER_SIGNED_EN.
module addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Subtract,
  output logic [W-1:0] Result,
  output logic         FlagC
);
  logic [W:0] sum;

  // FlagC is the carry out; when subtracting it means "no borrow".
  assign sum    = {1'b0, A} + {1'b0, (Subtract ? ~B : B)} + {{W{1'b0}}, Subtract};
  assign Result = sum[W-1:0];
  assign FlagC  = sum[W];
endmodule

module seq_divider #(
  parameter int N = 32
) (
  input  logic           clock,
  input  logic           reset_n,
  seq_divider_if.slave   bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifdef SEQ_DIVIDER_SIGNED_EN
  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t        state;
  logic [CW-1:0] count;
  logic [N-1:0]  rem_reg;
  logic [N-1:0]  dvd_reg;
  logic [N-1:0]  dvs_reg;
  logic [N-1:0]  quotient;
  logic [N-1:0]  remainder;
  logic          busy;
  logic          done;
  logic          div_by_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic          neg_q;
  logic          neg_r;
  logic [N-1:0]  dvd_mag;
  logic [N-1:0]  dvs_mag;
`endif

  logic [N:0]    shifted;
  logic [N:0]    diff;
  logic          no_borrow;
  logic [N:0]    rem_next;
  logic [N-1:0]  quo_next;
  logic          unused_rem_msb;

  // dvd_reg doubles as the quotient shift register: dividend bits leave at
  // the top while quotient bits enter at the bottom.
  assign shifted  = {rem_reg, dvd_reg[N-1]};
  assign rem_next = no_borrow ? diff : shifted;
  assign quo_next = {dvd_reg[N-2:0], no_borrow};
  assign unused_rem_msb = rem_next[N];

  addsub #(.W(N + 1)) u_addsub (
    .A        (shifted),
    .B        ({1'b0, dvs_reg}),
    .Subtract (1'b1),
    .Result   (diff),
    .FlagC    (no_borrow)
  );

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign dvd_mag = (bus.Signed && bus.Dividend[N-1]) ? -bus.Dividend : bus.Dividend;
  assign dvs_mag = (bus.Signed && bus.Divisor[N-1])  ? -bus.Divisor  : bus.Divisor;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      rem_reg     <= '0;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            count       <= CW'(N - 1);
            rem_reg     <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            dvd_reg     <= dvd_mag;
            dvs_reg     <= dvs_mag;
            neg_q       <= bus.Signed & (bus.Dividend[N-1] ^ bus.Divisor[N-1]);
            neg_r       <= bus.Signed & bus.Dividend[N-1];
`else
            dvd_reg     <= bus.Dividend;
            dvs_reg     <= bus.Divisor;
`endif
            if (bus.Divisor == '0) begin
              // Zero divisor skips the datapath entirely.
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= bus.Dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem_reg <= rem_next[N-1:0];
          dvd_reg <= quo_next;
          count   <= count - 1'b1;
          if (count == '0) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            state     <= FIXUP;
`else
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= quo_next;
            remainder <= rem_next[N-1:0];
`endif
          end
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        FIXUP: begin
          // Magnitude negation also yields MIN/-1 = MIN with remainder 0.
          state     <= DONE;
          done      <= 1'b1;
          quotient  <= neg_q ? -dvd_reg : dvd_reg;
          remainder <= neg_r ? -rem_reg : rem_reg;
        end
`endif
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Quotient  = quotient;
  assign bus.Remainder = remainder;
  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.DivByZero = div_by_zero;
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: N, default 32, operand/result width in bits.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-004 Start  input  1  request a division; sampled only when Busy=0.
REQ-005 Dividend  input  N  numerator, captured on an accepted Start.
REQ-006 Divisor  input  N  denominator, captured on an accepted Start.
REQ-007 Quotient  output  N  registered quotient, held until the next accepted Start.
REQ-008 Remainder  output  N  registered remainder, held until the next accepted Start.
REQ-009 Busy  output  1  high while a division is in progress.
REQ-010 Done  output  1  single-cycle pulse when Quotient/Remainder become valid.
REQ-011 DivByZero  output  1  registered; set with Done when the captured Divisor was 0.

Function
REQ-012 States SHALL be IDLE, RUN and DONE.
REQ-013 IDLE: Start=1 is accepted; operands are captured; step counter is loaded with N-1; partial remainder is cleared; the state goes to RUN, or to DONE if Divisor==0.
REQ-014 RUN, each cycle: partial remainder (N+1 bits) shifts left one bit, taking the next dividend MSB.
REQ-015 RUN, each cycle: the shifted value has the divisor trial-subtracted through an internal addsub instance of width N+1 with Subtract=1.
REQ-016 RUN, each cycle: if the adder's FlagC=1 (no borrow), the difference is kept and quotient bit=1; otherwise the shifted value is kept and quotient bit=0.
REQ-017 RUN SHALL last exactly N cycles; the state then goes to DONE.
REQ-018 DONE, one cycle: Quotient/Remainder are updated, Done=1, and the state returns to IDLE.
REQ-019 Latency: an accepted Start at edge k gives Done=1 during cycle k+N+1 (k+1 for divide-by-zero); Busy=1 from k+1 until Done, inclusive.
REQ-020 Start while Busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-021 Start asserted during the Done cycle is ignored; Start is accepted again from the following cycle.
REQ-022 Divide-by-zero results: Quotient=all ones, Remainder=Dividend, DivByZero=1.
REQ-023 Divide-by-zero SHALL be reported with no RUN cycles.
REQ-024 DivByZero SHALL be cleared on the next accepted Start.
REQ-025 Quotient/Remainder SHALL NOT change except in the DONE cycle or on reset.

Reset
REQ-026 reset_n=0 SHALL force IDLE immediately.
REQ-027 reset_n=0 SHALL clear Quotient, Remainder, Busy, Done, DivByZero, the step counter and all datapath registers to 0.
REQ-028 Reset mid-RUN SHALL abort the division with no Done pulse.
REQ-029 After reset deassertion, Start is accepted on the first rising edge.

Configuration
REQ-030 Macro SEQ_DIVIDER_SIGNED_EN: when defined, an input Signed (1 bit) is added and captured with Start.
REQ-031 With SEQ_DIVIDER_SIGNED_EN and Signed=1, the operands are treated as two's complement.
REQ-032 With SEQ_DIVIDER_SIGNED_EN and Signed=1, magnitudes are divided, the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign.
REQ-033 With SEQ_DIVIDER_SIGNED_EN, sign fixup SHALL add one FIXUP state between RUN and DONE, raising latency to N+2.
REQ-034 With SEQ_DIVIDER_SIGNED_EN and Signed=1, most-negative / -1 SHALL give Quotient=most-negative and Remainder=0.
REQ-035 With SEQ_DIVIDER_SIGNED_EN, divide-by-zero behaviour is per REQ-022 regardless of Signed.
REQ-036 Without the macro: no Signed port, unsigned-only operation, no FIXUP state, and latency per REQ-019.

Verification (N=32)
REQ-037 Dividend=100, Divisor=7, Start pulse -> Done exactly 33 cycles after accept; Quotient=14, Remainder=2; Busy high for 33 cycles.
REQ-038 Dividend=0xFFFFFFFF, Divisor=1 -> Quotient=0xFFFFFFFF, Remainder=0; then Dividend=5, Divisor=9 -> Quotient=0, Remainder=5.
REQ-039 Dividend=1234, Divisor=0 -> Done 1 cycle after accept; Quotient=0xFFFFFFFF, Remainder=1234, DivByZero=1; next accepted Start clears DivByZero.
REQ-040 Start re-pulsed with Dividend=9, Divisor=3 during RUN of 100/7 -> result stays 14 r 2; Start held high through Done -> a new operation is accepted only the cycle after Done.
REQ-041 reset_n pulsed low at RUN cycle 10 -> all outputs 0 immediately, no Done pulse; a following Start of 50/5 -> Quotient=10, Remainder=0.
REQ-042 With SEQ_DIVIDER_SIGNED_EN, Signed=1: -7/2 -> Quotient=-3, Remainder=-1 at latency 34; 0x80000000/-1 -> Quotient=0x80000000, Remainder=0.
